// File: rtl/tcp_rx_msg_noc_if_out_ctrl_pkg.sv
// Shared types and constants for the TCP RX message/pointer NoC egress.
// Covers the NoC header layout, message types, the response body and the FSM state.
package tcp_rx_msg_noc_if_out_ctrl_pkg;
  localparam int XY_WIDTH         = 8;
  localparam int NOC_FBITS_WIDTH  = 4;
  localparam int NOC_DATA_WIDTH   = 512;
  localparam int FLOW_ID_W        = 16;
  localparam int RX_PAYLOAD_PTR_W = 32;
  localparam int MSG_LEN_W        = 16;
  localparam int NOC_MSG_LEN_W    = 22;
  localparam int NOC_MSG_TYPE_W   = 8;
  localparam int DST_W            = 2*XY_WIDTH + NOC_FBITS_WIDTH;
  localparam int HDR_USED_W       = 2*DST_W + NOC_MSG_LEN_W + NOC_MSG_TYPE_W;

  localparam logic [NOC_MSG_TYPE_W-1:0] TCP_RX_MSG_RESP       = 8'h40;
  localparam logic [NOC_MSG_TYPE_W-1:0] TCP_RX_ADJUST_PTR_ACK = 8'h41;

  typedef enum logic [1:0] {READY = 2'd0, HDR = 2'd1, BODY = 2'd2} out_state_e;
  typedef enum logic {SRC_MSG = 1'b0, SRC_ACK = 1'b1} resp_src_e;

  typedef struct packed {
    logic [FLOW_ID_W-1:0]        flowid;
    logic [RX_PAYLOAD_PTR_W-1:0] ptr;
    logic [MSG_LEN_W-1:0]        len;
  } tcp_rx_msg_resp_body;

  typedef struct packed {
    logic [XY_WIDTH-1:0]                  dst_x;
    logic [XY_WIDTH-1:0]                  dst_y;
    logic [NOC_FBITS_WIDTH-1:0]           dst_fbits;
    logic [NOC_MSG_LEN_W-1:0]             msg_len;
    logic [NOC_MSG_TYPE_W-1:0]            msg_type;
    logic [XY_WIDTH-1:0]                  src_x;
    logic [XY_WIDTH-1:0]                  src_y;
    logic [NOC_FBITS_WIDTH-1:0]           src_fbits;
    logic [NOC_DATA_WIDTH-HDR_USED_W-1:0] rsvd;
  } beehive_noc_hdr_flit;
endpackage

// File: rtl/tcp_rx_msg_noc_if_out_ctrl_if.sv
// Request sources (poller message, pointer-adjust ack) and the NoC egress port.
// slave = the egress controller view, master = the surrounding logic view.
interface tcp_rx_msg_noc_if_out_ctrl_if
  import tcp_rx_msg_noc_if_out_ctrl_pkg::*;
#(
  parameter int FLOWID_W = FLOW_ID_W,
  parameter int PTR_W    = RX_PAYLOAD_PTR_W,
  parameter int LEN_W    = MSG_LEN_W
);
  logic                      poller_noc_if_msg_val;
  logic [FLOWID_W-1:0]       poller_noc_if_msg_flowid;
  logic [PTR_W-1:0]          poller_noc_if_msg_ptr;
  logic [LEN_W-1:0]          poller_noc_if_msg_len;
  logic [DST_W-1:0]          poller_noc_if_msg_dst;
  logic                      noc_if_poller_msg_rdy;
  logic                      ptr_adj_noc_if_ack_val;
  logic [FLOWID_W-1:0]       ptr_adj_noc_if_ack_flowid;
  logic [DST_W-1:0]          ptr_adj_noc_if_ack_dst;
  logic                      noc_if_ptr_adj_ack_rdy;
  logic                      tcp_rx_ptr_if_noc_val;
  logic [NOC_DATA_WIDTH-1:0] tcp_rx_ptr_if_noc_data;
  logic                      noc_tcp_rx_ptr_if_rdy;

  modport slave (
    input  poller_noc_if_msg_val, poller_noc_if_msg_flowid, poller_noc_if_msg_ptr,
           poller_noc_if_msg_len, poller_noc_if_msg_dst,
    output noc_if_poller_msg_rdy,
    input  ptr_adj_noc_if_ack_val, ptr_adj_noc_if_ack_flowid, ptr_adj_noc_if_ack_dst,
    output noc_if_ptr_adj_ack_rdy,
    output tcp_rx_ptr_if_noc_val, tcp_rx_ptr_if_noc_data,
    input  noc_tcp_rx_ptr_if_rdy
  );

  modport master (
    output poller_noc_if_msg_val, poller_noc_if_msg_flowid, poller_noc_if_msg_ptr,
           poller_noc_if_msg_len, poller_noc_if_msg_dst,
    input  noc_if_poller_msg_rdy,
    output ptr_adj_noc_if_ack_val, ptr_adj_noc_if_ack_flowid, ptr_adj_noc_if_ack_dst,
    input  noc_if_ptr_adj_ack_rdy,
    input  tcp_rx_ptr_if_noc_val, tcp_rx_ptr_if_noc_data,
    output noc_tcp_rx_ptr_if_rdy
  );
endinterface

// File: rtl/tcp_rx_msg_noc_if_out_ctrl_flit_fmt.sv
// Combinational packer: header flit for either source, body flit {flowid, ptr, len}
// left-justified with zero padding below.
module tcp_rx_msg_noc_if_out_ctrl_flit_fmt
  import tcp_rx_msg_noc_if_out_ctrl_pkg::*;
#(
  parameter int SRC_X    = 0,
  parameter int SRC_Y    = 0,
  parameter int FLOWID_W = FLOW_ID_W,
  parameter int PTR_W    = RX_PAYLOAD_PTR_W,
  parameter int LEN_W    = MSG_LEN_W
) (
  input  resp_src_e                 src,
  input  logic [FLOWID_W-1:0]       flowid,
  input  logic [PTR_W-1:0]          ptr,
  input  logic [LEN_W-1:0]          len,
  input  logic [DST_W-1:0]          dst,
  output logic [NOC_DATA_WIDTH-1:0] hdr_flit,
  output logic [NOC_DATA_WIDTH-1:0] body_flit
);
  localparam int BODY_W   = $bits(tcp_rx_msg_resp_body);
  localparam int BODY_PAD = NOC_DATA_WIDTH - BODY_W;

  beehive_noc_hdr_flit hdr;
  tcp_rx_msg_resp_body body;

  always_comb begin
    hdr           = '0;
    hdr.dst_x     = dst[DST_W-1 -: XY_WIDTH];
    hdr.dst_y     = dst[DST_W-XY_WIDTH-1 -: XY_WIDTH];
    hdr.dst_fbits = dst[NOC_FBITS_WIDTH-1:0];
    // A message carries exactly one body flit; an ack is header-only.
    hdr.msg_len   = (src == SRC_MSG) ? NOC_MSG_LEN_W'(1) : '0;
    hdr.msg_type  = (src == SRC_MSG) ? TCP_RX_MSG_RESP : TCP_RX_ADJUST_PTR_ACK;
    hdr.src_x     = XY_WIDTH'(SRC_X);
    hdr.src_y     = XY_WIDTH'(SRC_Y);

    body        = '0;
    body.flowid = FLOW_ID_W'(flowid);
    body.ptr    = RX_PAYLOAD_PTR_W'(ptr);
    body.len    = MSG_LEN_W'(len);
  end

  assign hdr_flit  = hdr;
  assign body_flit = {body, {BODY_PAD{1'b0}}};
endmodule

// File: rtl/tcp_rx_msg_noc_if_out_ctrl.sv
// TCP RX egress: round-robin between poller notifications and pointer-adjust acks,
// latch the winner, then stream header (+ body for messages) onto the NoC.
module tcp_rx_msg_noc_if_out_ctrl
  import tcp_rx_msg_noc_if_out_ctrl_pkg::*;
#(
  parameter int SRC_X    = 0,
  parameter int SRC_Y    = 0,
  parameter int FLOWID_W = FLOW_ID_W,
  parameter int PTR_W    = RX_PAYLOAD_PTR_W,
  parameter int LEN_W    = MSG_LEN_W
) (
  input logic                        clk,
  input logic                        rst,
  tcp_rx_msg_noc_if_out_ctrl_if.slave bus
);
  if (FLOWID_W + PTR_W + LEN_W > NOC_DATA_WIDTH) begin : g_body_fit_err
    $error("body fields exceed NoC flit width");
  end
  if (FLOWID_W > FLOW_ID_W || PTR_W > RX_PAYLOAD_PTR_W || LEN_W > MSG_LEN_W) begin : g_field_fit_err
    $error("field wider than response body struct");
  end

  out_state_e state_q, state_d;
  resp_src_e  rr_q, rr_d, src_q;
  logic       grant_msg, grant_ack, noc_val;

  logic [FLOWID_W-1:0]       flowid_q;
  logic [PTR_W-1:0]          ptr_q;
  logic [LEN_W-1:0]          len_q;
  logic [DST_W-1:0]          dst_q;
  logic [NOC_DATA_WIDTH-1:0] hdr_flit, body_flit, noc_data;

  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    grant_msg = 1'b0;
    grant_ack = 1'b0;
    noc_val   = 1'b0;
    noc_data  = '0;
    case (state_q)
      READY: begin
        grant_msg = bus.poller_noc_if_msg_val &&
                    (!bus.ptr_adj_noc_if_ack_val || rr_q == SRC_MSG);
        grant_ack = bus.ptr_adj_noc_if_ack_val && !grant_msg;
        // Priority only rotates on real contention so a lone source never loses its turn.
        if (bus.poller_noc_if_msg_val && bus.ptr_adj_noc_if_ack_val)
          rr_d = grant_msg ? SRC_ACK : SRC_MSG;
        if (grant_msg || grant_ack)
          state_d = HDR;
      end
      HDR: begin
        noc_val  = 1'b1;
        noc_data = hdr_flit;
        if (bus.noc_tcp_rx_ptr_if_rdy)
          state_d = (src_q == SRC_MSG) ? BODY : READY;
      end
      BODY: begin
        noc_val  = 1'b1;
        noc_data = body_flit;
        if (bus.noc_tcp_rx_ptr_if_rdy)
          state_d = READY;
      end
      default: begin
        state_d   = READY;
        grant_msg = 1'bx;
        grant_ack = 1'bx;
        noc_val   = 1'bx;
        noc_data  = 'x;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= READY;
      rr_q     <= SRC_MSG;
      src_q    <= SRC_MSG;
      flowid_q <= '0;
      ptr_q    <= '0;
      len_q    <= '0;
      dst_q    <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      if (grant_msg) begin
        src_q    <= SRC_MSG;
        flowid_q <= bus.poller_noc_if_msg_flowid;
        ptr_q    <= bus.poller_noc_if_msg_ptr;
        len_q    <= bus.poller_noc_if_msg_len;
        dst_q    <= bus.poller_noc_if_msg_dst;
      end else if (grant_ack) begin
        src_q    <= SRC_ACK;
        flowid_q <= bus.ptr_adj_noc_if_ack_flowid;
        ptr_q    <= '0;
        len_q    <= '0;
        dst_q    <= bus.ptr_adj_noc_if_ack_dst;
      end
    end
  end

  tcp_rx_msg_noc_if_out_ctrl_flit_fmt #(
    .SRC_X(SRC_X), .SRC_Y(SRC_Y), .FLOWID_W(FLOWID_W), .PTR_W(PTR_W), .LEN_W(LEN_W)
  ) u_fmt (
    .src(src_q), .flowid(flowid_q), .ptr(ptr_q), .len(len_q), .dst(dst_q),
    .hdr_flit(hdr_flit), .body_flit(body_flit)
  );

  // Outputs are forced low while reset is held so an abandoned packet drops immediately.
  assign bus.noc_if_poller_msg_rdy  = grant_msg & ~rst;
  assign bus.noc_if_ptr_adj_ack_rdy = grant_ack & ~rst;
  assign bus.tcp_rx_ptr_if_noc_val  = noc_val & ~rst;
  assign bus.tcp_rx_ptr_if_noc_data = rst ? '0 : noc_data;
endmodule
